uart_rx_ovs: RTL

Parametrised oversampling UART receiver; the next generation of the team's single-rate receiver. It synchronises the asynchronous RX pin and validates the start bit at mid-bit. It samples 5–8 data bits LSB-first, checks 1 or 2 stop bits, and optionally checks parity. Each frame is presented on a VALID/READY output with framing, parity and overrun status. It sits between the board RX pin and any byte-stream consumer (FIFO, command decoder).

---
 rtl/uart_pkg.sv | 29 ++
 rtl/baud_tick_gen.sv | 39 +++
 rtl/uart_rx_ovs.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and helpers for the oversampling UART receiver:
//             FSM state encoding, default oversample rate, counter widths.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states; the PARITY state is only entered when parity
    // checking is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Default oversample ticks per bit.
    localparam int OVS_DEFAULT = 16;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : baud_tick_gen
//  Purpose  : Free-running oversample tick enable. TICK is a one-cycle
//             enable once every DIV clocks, not a derived clock. CLR restarts
//             the phase so the first tick follows DIV clocks later.
//  Revision : 1.0  initial release
// ============================================================================
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DIV = 12
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    output logic TICK
);

    localparam int               c_cnt_w = cnt_width(DIV);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Divide-by-DIV counter; wraps on its last value or restarts on CLR.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (CLR || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign TICK = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ovs
//  Purpose  : Oversampling UART receiver. Synchronises RX, validates the
//             start bit at mid-bit, samples DATA_BITS data bits LSB-first,
//             an optional parity bit and STOP_BITS stop bits, and presents
//             each frame on a VALID/READY port with framing, parity and
//             sticky overrun status.
//  Config   : define UART_RX_PARITY_EN to expect one parity bit after the
//             data bits and make PARITY_ERR live.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_ovs
    import uart_pkg::*;
#(
    parameter int DIV        = 12,
    parameter int OVS        = OVS_DEFAULT,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    input  logic                 READY,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    localparam int c_tw = cnt_width(OVS);
    localparam int c_bw = cnt_width(DATA_BITS);

    localparam logic [c_tw-1:0] c_half  = c_tw'(OVS / 2 - 1);
    localparam logic [c_tw-1:0] c_full  = c_tw'(OVS - 1);
    localparam logic [c_bw-1:0] c_blast = c_bw'(DATA_BITS - 1);
    localparam logic            c_slast = 1'(STOP_BITS - 1);
    localparam logic            c_odd   = (PARITY_ODD != 0);
`ifdef UART_RX_PARITY_EN
    localparam logic            c_par_en = 1'b1;
`else
    localparam logic            c_par_en = 1'b0;
`endif

    // Synchroniser and tick
    logic r_rx_meta;
    logic r_rxs;
    logic w_tick;
    logic w_tick_clr;

    // FSM and frame datapath
    uart_state_t          r_state,   w_state_nxt;
    logic [c_tw-1:0]      r_tcnt,    w_tcnt_nxt;
    logic [c_bw-1:0]      r_bcnt,    w_bcnt_nxt;
    logic                 r_scnt,    w_scnt_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic                 r_ferr_acc, w_ferr_nxt;
    logic                 r_perr_acc, w_perr_nxt;
    logic                 w_done;
    logic                 w_break;
    logic                 r_rearm;

    // Output holding registers
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_ovr;

    logic                 w_accept;
    logic                 w_load;

    // Two-flop synchroniser for the asynchronous RX pin; idles high.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rxs     <= r_rx_meta;
        end
    end

    baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (w_tick_clr),
        .TICK  (w_tick)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update: counters, shift register, error flags.
    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_bcnt_nxt  = r_bcnt;
        w_scnt_nxt  = r_scnt;
        w_shift_nxt = r_shift;
        w_ferr_nxt  = r_ferr_acc;
        w_perr_nxt  = r_perr_acc;
        w_tick_clr  = 1'b0;
        w_done      = 1'b0;
        w_break     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Start edge seen: realign the tick phase to the edge.
                if (!r_rxs && r_rearm) begin
                    w_state_nxt = ST_START;
                    w_tick_clr  = 1'b1;
                    w_tcnt_nxt  = '0;
                    w_bcnt_nxt  = '0;
                    w_scnt_nxt  = 1'b0;
                    w_ferr_nxt  = 1'b0;
                    w_perr_nxt  = 1'b0;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    if (r_tcnt == c_half) begin
                        // Mid start bit: still low means a real frame.
                        w_tcnt_nxt  = '0;
                        w_state_nxt = r_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        w_tcnt_nxt = r_tcnt + c_tw'(1);
                    end
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    if (r_tcnt == c_full) begin
                        w_tcnt_nxt          = '0;
                        w_shift_nxt[r_bcnt] = r_rxs;
                        if (r_bcnt == c_blast) begin
                            w_bcnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = ST_PARITY;
`else
                            w_state_nxt = ST_STOP;
`endif
                        end else begin
                            w_bcnt_nxt = r_bcnt + c_bw'(1);
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + c_tw'(1);
                    end
                end
            end

            ST_PARITY: begin
                // Only reachable when parity checking is compiled in.
                if (w_tick) begin
                    if (r_tcnt == c_full) begin
                        w_tcnt_nxt  = '0;
                        w_perr_nxt  = r_rxs ^ (^r_shift) ^ c_odd;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_tcnt_nxt = r_tcnt + c_tw'(1);
                    end
                end
            end

            ST_STOP: begin
                if (w_tick) begin
                    if (r_tcnt == c_full) begin
                        w_tcnt_nxt = '0;
                        if (!r_rxs) begin
                            w_ferr_nxt = 1'b1;
                        end
                        if (r_scnt == c_slast) begin
                            // Leave at mid-stop so the next start edge is caught early.
                            w_done      = 1'b1;
                            w_break     = !r_rxs;
                            w_scnt_nxt  = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_scnt_nxt = 1'b1;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + c_tw'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_tcnt     <= '0;
            r_bcnt     <= '0;
            r_scnt     <= 1'b0;
            r_shift    <= '0;
            r_ferr_acc <= 1'b0;
            r_perr_acc <= 1'b0;
        end else begin
            r_tcnt     <= w_tcnt_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_scnt     <= w_scnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ferr_acc <= w_ferr_nxt;
            r_perr_acc <= w_perr_nxt;
        end
    end

    // Re-arm flag: a frame ending in a low stop sample blocks new starts
    // until the line has been seen high on a tick, so a break yields one frame.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rearm <= 1'b1;
        end else if (w_break) begin
            r_rearm <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_tick && r_rxs) begin
            r_rearm <= 1'b1;
        end
    end

    assign w_accept = r_valid && READY;
    assign w_load   = w_done && (!r_valid || READY);

    // Output slot: load a finished frame when free or being drained,
    // otherwise drop it and flag overrun; clear on handshake.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= w_shift_nxt;
                r_valid <= 1'b1;
                r_ferr  <= w_ferr_nxt;
                r_perr  <= r_perr_acc;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            if (w_done && !w_load) begin
                r_ovr <= 1'b1;
            end else if (w_accept) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign DATA       = r_data;
    assign VALID      = r_valid;
    assign FRAME_ERR  = r_ferr;
    assign PARITY_ERR = r_perr & c_par_en;
    assign OVERRUN    = r_ovr;
    assign BUSY       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
